// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - frame FIFO that publishes only complete frames, with rewind, release and overflow stretch
module frame_buffer #(
  parameter int DATA_W        = 16,
  parameter int FRAME_LOG2    = 3,
  parameter int DEPTH_LOG2    = 10,
  parameter int OVF_STRETCH_W = 26
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_valid,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             wr_abort,
  input  logic                             rd_next,
  input  logic                             rd_rewind,
  input  logic                             rd_release,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             data_ready,
  output logic                             frame_ready,
  output logic [DEPTH_LOG2-FRAME_LOG2:0]   frame_count,
  output logic                             ovf,
  output logic                             ovf_led
);

  localparam int FW = DEPTH_LOG2 - FRAME_LOG2;
  localparam int NF = 2 ** FW;
  localparam logic [FW:0] NF_CNT = (FW + 1)'(NF);

  logic [DATA_W-1:0]        mem [0:2**DEPTH_LOG2-1];
  logic [FW-1:0]            wrFrame;
  logic [FW-1:0]            rdFrame;
  logic [FRAME_LOG2-1:0]    wrOff;
  logic [FRAME_LOG2:0]      rdOff;
  logic [FW:0]              cnt;
  logic                     ovfReg;
  logic [OVF_STRETCH_W-1:0] stretch;

  logic full;
  logic frameReady;
  logic dataReady;
  logic wrAccept;
  logic commit;
  logic doRelease;
  logic doNext;

  always_comb begin
    full       = (cnt == NF_CNT);
    frameReady = (cnt != '0);
    // rdOff never exceeds FS, so its top bit alone marks the end of the frame
    dataReady  = frameReady && !rdOff[FRAME_LOG2];
    wrAccept   = !wr_abort && wr_valid && !ovfReg && !full;
    commit     = wrAccept && (&wrOff);
    doRelease  = rd_release && frameReady;
    doNext     = rd_next && dataReady;
  end

  always_ff @(posedge clk) begin
    if (!rst && wrAccept) begin
      mem[{wrFrame, wrOff}] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrFrame <= '0;
      wrOff   <= '0;
      rdFrame <= '0;
      rdOff   <= '0;
      cnt     <= '0;
      ovfReg  <= 1'b0;
      stretch <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[{rdFrame, rdOff[FRAME_LOG2-1:0]}];

      if (wr_abort) begin
        wrOff  <= '0;
        ovfReg <= 1'b0;
      end else if (wr_valid && !ovfReg && full) begin
        ovfReg <= 1'b1;
      end else if (wrAccept) begin
        wrOff <= wrOff + 1'b1;
        if (commit) begin
          wrFrame <= wrFrame + 1'b1;
        end
      end

      if (doRelease) begin
        rdFrame <= rdFrame + 1'b1;
        rdOff   <= '0;
      end else if (rd_rewind) begin
        rdOff <= '0;
      end else if (doNext) begin
        rdOff <= rdOff + 1'b1;
      end

      if (commit && !doRelease) begin
        cnt <= cnt + 1'b1;
      end else if (doRelease && !commit) begin
        cnt <= cnt - 1'b1;
      end

      if (ovfReg) begin
        stretch <= '1;
      end else if (stretch != '0) begin
        stretch <= stretch - 1'b1;
      end
    end
  end

  assign data_ready  = dataReady;
  assign frame_ready = frameReady;
  assign frame_count = cnt;
  assign ovf         = ovfReg;
  assign ovf_led     = (stretch != '0);

endmodule

// File: tb/tb_frame_buffer.sv
// tb/tb_frame_buffer.sv - directed vectors and sequences for frame_buffer (FS=8, NF=4)
module tb_frame_buffer;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              wrValid;
  logic [DATA_W-1:0] wrData;
  logic              wrAbort;
  logic              rdNext;
  logic              rdRewind;
  logic              rdRelease;
  logic [DATA_W-1:0] rdData;
  logic              dataReady;
  logic              frameReady;
  logic [2:0]        frameCount;
  logic              ovf;
  logic              ovfLed;

  int nCmp = 0;
  int nErr = 0;

  frame_buffer #(
    .DATA_W(16), .FRAME_LOG2(3), .DEPTH_LOG2(5), .OVF_STRETCH_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wrValid), .wr_data(wrData), .wr_abort(wrAbort),
    .rd_next(rdNext), .rd_rewind(rdRewind), .rd_release(rdRelease),
    .rd_data(rdData), .data_ready(dataReady), .frame_ready(frameReady),
    .frame_count(frameCount), .ovf(ovf), .ovf_led(ovfLed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [15:0] wd;
    logic        ab;
    logic        nx;
    logic        rw;
    logic        rl;
    logic [2:0]  fc;
    logic        fr;
    logic        dr;
    logic        chkD;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkVec(logic wv, logic [15:0] wd, logic ab, logic nx, logic rw, logic rl,
                                 logic [2:0] fc, logic fr, logic dr, logic chkD, logic [15:0] rd);
    vec_t v;
    v.wv = wv; v.wd = wd; v.ab = ab; v.nx = nx; v.rw = rw; v.rl = rl;
    v.fc = fc; v.fr = fr; v.dr = dr; v.chkD = chkD; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [15:0] wd, input logic ab,
                       input logic nx, input logic rw, input logic rl);
    rst = 1'b0; wrValid = wv; wrData = wd; wrAbort = ab;
    rdNext = nx; rdRewind = rw; rdRelease = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic writeFrame(input string nm, input logic [15:0] base, input int fcBefore, input logic relAtLast);
    for (int w = 0; w < 8; w++) begin
      drive(1, base + 16'(w), 0, 0, 0, (w == 7) && relAtLast);
      if (w == 7)
        chk($sformatf("%s.fcCommit", nm), 32'(frameCount), relAtLast ? fcBefore : fcBefore + 1);
      else
        chk($sformatf("%s.fc[%0d]", nm, w), 32'(frameCount), fcBefore);
    end
  endtask

  task automatic readFrame(input string nm, input logic [15:0] base);
    for (int w = 0; w < 8; w++) begin
      drive(0, 16'h0, 0, 1, 0, 0);
      chk($sformatf("%s.rd[%0d]", nm, w), 32'(rdData), 32'(base + 16'(w)));
    end
    chk($sformatf("%s.drEnd", nm), 32'(dataReady), 0);
  endtask

  initial begin
    rst = 1'b1; wrValid = 0; wrData = '0; wrAbort = 0; rdNext = 0; rdRewind = 0; rdRelease = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset.fc", 32'(frameCount), 0);
    chk("reset.fr", 32'(frameReady), 0);
    chk("reset.dr", 32'(dataReady), 0);
    chk("reset.rd", 32'(rdData), 0);
    chk("reset.ovf", 32'(ovf), 0);
    chk("reset.led", 32'(ovfLed), 0);

    // Test 1 as a vector table: one frame written then read word by word
    for (int w = 0; w < 8; w++)
      tbl.push_back(mkVec(1, 16'h100 + 16'(w), 0, 0, 0, 0, (w == 7) ? 3'd1 : 3'd0,
                          w == 7, w == 7, w == 7, 16'h100));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mkVec(0, 16'h0, 0, 1, 0, 0, 3'd1, 1, k < 8, 1, 16'h100 + 16'(k - 1)));
    tbl.push_back(mkVec(0, 16'h0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 16'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].wv, tbl[i].wd, tbl[i].ab, tbl[i].nx, tbl[i].rw, tbl[i].rl);
      chk($sformatf("t1.fc[%0d]", i), 32'(frameCount), 32'(tbl[i].fc));
      chk($sformatf("t1.fr[%0d]", i), 32'(frameReady), 32'(tbl[i].fr));
      chk($sformatf("t1.dr[%0d]", i), 32'(dataReady), 32'(tbl[i].dr));
      if (tbl[i].chkD)
        chk($sformatf("t1.rd[%0d]", i), 32'(rdData), 32'(tbl[i].rd));
    end

    // Test 2: abort discards a partial frame (wr_valid ignored on the abort cycle)
    for (int w = 0; w < 5; w++) begin
      drive(1, 16'h2F0 + 16'(w), 0, 0, 0, 0);
      chk($sformatf("t2.partFc[%0d]", w), 32'(frameCount), 0);
    end
    drive(1, 16'hEEE, 1, 0, 0, 0);
    chk("t2.abortFc", 32'(frameCount), 0);
    writeFrame("t2", 16'h200, 0, 0);
    chk("t2.word0", 32'(rdData), 32'h200);

    // Test 3: rewind and release
    for (int w = 0; w < 3; w++) begin
      drive(0, 16'h0, 0, 1, 0, 0);
      chk($sformatf("t3.rd[%0d]", w), 32'(rdData), 32'(16'h200 + 16'(w)));
    end
    drive(0, 16'h0, 0, 0, 1, 0);
    drive(0, 16'h0, 0, 1, 0, 0);
    chk("t3.rewindWord0", 32'(rdData), 32'h200);
    chk("t3.rewindDr", 32'(dataReady), 1);
    writeFrame("t3", 16'h300, 1, 0);
    drive(0, 16'h0, 0, 0, 0, 1);
    chk("t3.relFc", 32'(frameCount), 1);
    idle();
    chk("t3.nextWord0", 32'(rdData), 32'h300);
    drive(0, 16'h0, 0, 0, 0, 1);
    chk("t3.rel2Fc", 32'(frameCount), 0);

    // Test 4: fill, overflow, abort, stretched led, frames intact
    for (int f = 0; f < 4; f++)
      writeFrame($sformatf("t4.fill%0d", f), 16'h400 + 16'(f * 16), f, 0);
    chk("t4.fullOvf", 32'(ovf), 0);
    drive(1, 16'hBAD, 0, 0, 0, 0);
    chk("t4.ovfSet", 32'(ovf), 1);
    chk("t4.ovfFc", 32'(frameCount), 4);
    idle();
    chk("t4.ledOn", 32'(ovfLed), 1);
    drive(1, 16'hBAD2, 0, 0, 0, 0);
    chk("t4.ovfSticky", 32'(ovf), 1);
    drive(0, 16'h0, 1, 0, 0, 0);
    chk("t4.ovfClr", 32'(ovf), 0);
    chk("t4.ledHeld", 32'(ovfLed), 1);
    for (int k = 0; k < 14; k++) idle();
    chk("t4.led14", 32'(ovfLed), 1);
    idle();
    chk("t4.led15", 32'(ovfLed), 0);
    for (int f = 0; f < 4; f++) begin
      readFrame($sformatf("t4.read%0d", f), 16'h400 + 16'(f * 16));
      drive(0, 16'h0, 0, 0, 0, 1);
      chk($sformatf("t4.relFc%0d", f), 32'(frameCount), 3 - f);
    end

    // Test 5: alternate commit/release across index wrap, then release with commit
    for (int i = 0; i < 10; i++) begin
      writeFrame($sformatf("t5.w%0d", i), 16'h500 + 16'(i * 16), 0, 0);
      readFrame($sformatf("t5.r%0d", i), 16'h500 + 16'(i * 16));
      drive(0, 16'h0, 0, 0, 0, 1);
      chk($sformatf("t5.rel%0d", i), 32'(frameCount), 0);
    end
    writeFrame("t5.a", 16'h600, 0, 0);
    writeFrame("t5.b", 16'h610, 1, 1);
    readFrame("t5.rb", 16'h610);
    drive(0, 16'h0, 0, 0, 0, 1);
    chk("t5.relB", 32'(frameCount), 0);

    // Test 6: idle-state guards, read past end, reset mid-write
    drive(0, 16'h0, 0, 0, 0, 1);
    chk("t6.emptyRelFc", 32'(frameCount), 0);
    chk("t6.emptyRelFr", 32'(frameReady), 0);
    drive(0, 16'h0, 0, 1, 0, 0);
    chk("t6.emptyNextFc", 32'(frameCount), 0);
    chk("t6.emptyNextDr", 32'(dataReady), 0);
    writeFrame("t6.w", 16'h700, 0, 0);
    readFrame("t6.r", 16'h700);
    for (int k = 0; k < 2; k++) begin
      drive(0, 16'h0, 0, 1, 0, 0);
      chk($sformatf("t6.pastDr%0d", k), 32'(dataReady), 0);
      chk($sformatf("t6.pastFc%0d", k), 32'(frameCount), 1);
    end
    drive(0, 16'h0, 0, 0, 1, 0);
    drive(0, 16'h0, 0, 1, 0, 0);
    chk("t6.rewindWord0", 32'(rdData), 32'h700);
    for (int f = 0; f < 3; f++)
      writeFrame($sformatf("t6.fill%0d", f), 16'h710 + 16'(f * 16), f + 1, 0);
    drive(1, 16'hBAD, 0, 0, 0, 0);
    drive(0, 16'h0, 1, 0, 0, 0);
    drive(0, 16'h0, 0, 0, 0, 1);
    chk("t6.preRstFc", 32'(frameCount), 3);
    for (int w = 0; w < 3; w++) drive(1, 16'h7A0 + 16'(w), 0, 0, 0, 0);
    chk("t6.preRstLed", 32'(ovfLed), 1);
    rst = 1'b1; wrValid = 1'b1; wrData = 16'h7A3;
    @(posedge clk); #1;
    chk("t6.rstFc", 32'(frameCount), 0);
    chk("t6.rstFr", 32'(frameReady), 0);
    chk("t6.rstDr", 32'(dataReady), 0);
    chk("t6.rstRd", 32'(rdData), 0);
    chk("t6.rstOvf", 32'(ovf), 0);
    chk("t6.rstLed", 32'(ovfLed), 0);
    writeFrame("t6.post", 16'h800, 0, 0);
    readFrame("t6.postR", 16'h800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
